// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg
// Shared constants for the data-side memory map. The data cache and the
// memory controller both use these, so the MMIO window and the register
// offsets are defined in exactly one place.
//
// Contents:
//   MMIO_BASE      value of mem_addr[19:16] that selects the MMIO window
//   OFF_*          MMIO register offsets (mem_addr[7:0])
//   mmio_req_t     write request handed from the top level to mmio_regs
//   is_mmio()      region decode helper
package data_mem_ctrl_pkg;

  localparam logic [3:0] MMIO_BASE = 4'hF;

  localparam logic [7:0] OFF_SW       = 8'h00;
  localparam logic [7:0] OFF_BTN      = 8'h04;
  localparam logic [7:0] OFF_BTN_EDGE = 8'h08;
  localparam logic [7:0] OFF_LED      = 8'h10;
  localparam logic [7:0] OFF_SEG      = 8'h14;
  localparam logic [7:0] OFF_CYCLE    = 8'h20;
  localparam logic [7:0] OFF_MS       = 8'h24;

  localparam int NUM_SW  = 16;
  localparam int NUM_BTN = 5;

  typedef struct packed {
    logic        we;
    logic [7:0]  off;
    logic [31:0] wdata;
  } mmio_req_t;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[19:16] == MMIO_BASE;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_mmio_regs.sv
// mmio_regs
// Memory-mapped register file of the data memory controller: input
// synchronizers, sticky button-edge latch, LED / seven-segment registers
// and the optional cycle / millisecond timers.
//
// Build option: define MMIO_TIMER_EN to include the CYCLE and MS timers.
// Without it CYCLE and MS read as zero and no timer logic exists.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   req         write request (already qualified with region and reset)
//   switches    raw board switches (asynchronous)
//   buttons     raw board buttons (asynchronous, active-high)
//   rd_off      read offset (mem_addr[7:0])
//   rd_data     combinational read data for rd_off
//   led         LED register
//   seg_data    seven-segment register
module mmio_regs
  import data_mem_ctrl_pkg::*;
#(
  parameter int MS_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  mmio_req_t            req,
  input  logic [NUM_SW-1:0]    switches,
  input  logic [NUM_BTN-1:0]   buttons,
  input  logic [7:0]           rd_off,
  output logic [31:0]          rd_data,
  output logic [15:0]          led,
  output logic [31:0]          seg_data
);

  logic [NUM_SW-1:0]  sw_s1, sw_s2;
  logic [NUM_BTN-1:0] btn_s1, btn_s2, btn_s3;
  logic [NUM_BTN-1:0] btn_edge;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_clr;
  logic [31:0]        cycle_val;
  logic [31:0]        ms_val;

  // Two flops for metastability; btn_s3 is only the edge-detect history
  // so that edge detection sees fully synchronized values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_s3 <= '0;
    end else begin
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
      btn_s1 <= buttons;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign btn_rise = btn_s2 & ~btn_s3;
  assign btn_clr  = (req.we && req.off == OFF_BTN_EDGE) ? req.wdata[NUM_BTN-1:0] : '0;

  // Set is OR-ed in after the clear so a same-cycle edge survives the W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_edge <= '0;
    end else begin
      btn_edge <= (btn_edge & ~btn_clr) | btn_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= '0;
      seg_data <= '0;
    end else if (req.we) begin
      if (req.off == OFF_LED) led      <= req.wdata[15:0];
      if (req.off == OFF_SEG) seg_data <= req.wdata;
    end
  end

`ifdef MMIO_TIMER_EN
  localparam int PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MS_DIV - 1);

  logic [31:0]      cycle_cnt;
  logic [31:0]      ms_cnt;
  logic [PRE_W-1:0] pre_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // A software load restarts the millisecond period from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_cnt  <= '0;
      pre_cnt <= '0;
    end else if (req.we && req.off == OFF_MS) begin
      ms_cnt  <= req.wdata;
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_MAX) begin
      ms_cnt  <= ms_cnt + 32'd1;
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign cycle_val = cycle_cnt;
  assign ms_val    = ms_cnt;
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = ^32'(MS_DIV);
  assign cycle_val = '0;
  assign ms_val    = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_off)
      OFF_SW:       rd_data = 32'(sw_s2);
      OFF_BTN:      rd_data = 32'(btn_s2);
      OFF_BTN_EDGE: rd_data = 32'(btn_edge);
      OFF_LED:      rd_data = 32'(led);
      OFF_SEG:      rd_data = seg_data;
      OFF_CYCLE:    rd_data = cycle_val;
      OFF_MS:       rd_data = ms_val;
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Data-side memory controller: a word-addressed RAM plus an MMIO window
// (mem_addr[19:16] == MMIO_BASE) served by mmio_regs. Reads have one cycle
// of latency through the mem_data register; RAM is read-first.
//
// Build option: MMIO_TIMER_EN enables the CYCLE / MS timers in mmio_regs.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   mem_addr          byte address from the data cache
//   mem_write_data    full-word write data
//   mem_web           1 = write this cycle
//   mem_data          registered read data
//   switches          raw board switches
//   buttons           raw board buttons
//   led               LED register
//   seg_data          seven-segment register
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int MEM_WID = 14,
  parameter int MS_DIV  = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_write_data,
  input  logic         mem_web,
  output logic [31:0]  mem_data,
  input  logic [15:0]  switches,
  input  logic [4:0]   buttons,
  output logic [15:0]  led,
  output logic [31:0]  seg_data
);

  logic [31:0]        ram [2**MEM_WID];
  logic [MEM_WID-1:0] word_idx;
  logic               mmio_sel;
  logic [31:0]        mmio_rd;
  mmio_req_t          mmio_req;
  logic               unused_addr;

  assign word_idx = mem_addr[MEM_WID+1:2];
  assign mmio_sel = is_mmio(mem_addr);
  // Only part of the address is decoded; the rest is deliberately ignored.
  assign unused_addr = ^mem_addr;

  assign mmio_req.we    = mem_web && mmio_sel && !rst;
  assign mmio_req.off   = mem_addr[7:0];
  assign mmio_req.wdata = mem_write_data;

  mmio_regs #(
    .MS_DIV (MS_DIV)
  ) u_mmio_regs (
    .clk      (clk),
    .rst      (rst),
    .req      (mmio_req),
    .switches (switches),
    .buttons  (buttons),
    .rd_off   (mem_addr[7:0]),
    .rd_data  (mmio_rd),
    .led      (led),
    .seg_data (seg_data)
  );

  // RAM contents survive reset; an access during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_web && !mmio_sel) begin
      ram[word_idx] <= mem_write_data;
    end
  end

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data <= '0;
    end else if (mmio_sel) begin
      mem_data <= mmio_rd;
    end else begin
      mem_data <= ram[word_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Randomized bench for data_mem_ctrl with a behavioural memory-map model
// and a scoreboard queue drained by an independent monitor.
module tb_data_mem_ctrl;

  localparam int MEM_WID = 14;
  localparam int MS_DIV  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_web;
  logic [31:0] mem_data;
  logic [15:0] switches;
  logic [4:0]  buttons;
  logic [15:0] led;
  logic [31:0] seg_data;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .MEM_WID (MEM_WID),
    .MS_DIV  (MS_DIV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_web        (mem_web),
    .mem_data       (mem_data),
    .switches       (switches),
    .buttons        (buttons),
    .led            (led),
    .seg_data       (seg_data)
  );

  typedef struct {
    bit          chk;
    logic [31:0] data;
    logic [15:0] led;
    logic [31:0] seg;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [15:0] sw_d1, sw_d2;
  logic [4:0]  b_d1, b_d2, b_d3;
  logic [4:0]  edge_m;
  logic [15:0] led_m;
  logic [31:0] seg_m;
  logic [31:0] ms_base;
  int          n_cyc;
  int          ms_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ms_now();
    return ms_base + 32'((n_cyc - ms_w - 1) / MS_DIV);
  endfunction

  task automatic model_reset();
    edge_m  = '0;
    led_m   = '0;
    seg_m   = '0;
    sw_d1   = '0;
    sw_d2   = '0;
    b_d1    = '0;
    b_d2    = '0;
    b_d3    = '0;
    n_cyc   = 0;
    ms_base = '0;
    ms_w    = -1;
  endtask

  // One access; the expected read result and outputs are queued at the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we);
    exp_t       e;
    logic [7:0] off;
    logic [4:0] rise;
    bit         mm;
    int         idx;
    rst            = 1'b0;
    mem_addr       = a;
    mem_write_data = wd;
    mem_web        = we;
    off = a[7:0];
    mm  = (a[19:16] == 4'hF);
    idx = int'(a[MEM_WID+1:2]);
    e.chk  = 1'b1;
    e.data = '0;
    if (mm) begin
      case (off)
        8'h00: e.data = {16'h0, sw_d2};
        8'h04: e.data = {27'h0, b_d2};
        8'h08: e.data = {27'h0, edge_m};
        8'h10: e.data = {16'h0, led_m};
        8'h14: e.data = seg_m;
`ifdef MMIO_TIMER_EN
        8'h20: e.data = 32'(n_cyc);
        8'h24: e.data = ms_now();
`endif
        default: e.data = '0;
      endcase
    end else if (ram_m.exists(idx)) begin
      e.data = ram_m[idx];
    end else begin
      e.chk = 1'b0;
    end
    rise = b_d2 & ~b_d3;
    if (we && mm && off == 8'h08) edge_m = (edge_m & ~wd[4:0]) | rise;
    else                          edge_m = edge_m | rise;
    if (we) begin
      if (mm) begin
        case (off)
          8'h10: led_m = wd[15:0];
          8'h14: seg_m = wd;
`ifdef MMIO_TIMER_EN
          8'h24: begin
            ms_base = wd;
            ms_w    = n_cyc;
          end
`endif
          default: ;
        endcase
      end else begin
        ram_m[idx] = wd;
      end
    end
    sw_d2 = sw_d1;
    sw_d1 = switches;
    b_d3  = b_d2;
    b_d2  = b_d1;
    b_d1  = buttons;
    n_cyc++;
    e.led = led_m;
    e.seg = seg_m;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  // Reset cycle with a write attempt that must be dropped.
  task automatic rst_step(input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    rst            = 1'b1;
    mem_addr       = a;
    mem_write_data = wd;
    mem_web        = 1'b1;
    model_reset();
    e.chk  = 1'b1;
    e.data = '0;
    e.led  = '0;
    e.seg  = '0;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle();
    step(32'h0000_0040, 32'h0, 1'b0);
  endtask

  // Monitor: one registered result per clock.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) check("mem_data", mem_data, e.data);
      check("led", {16'h0, led}, {16'h0, e.led});
      check("seg", seg_data, e.seg);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] r;
    logic [7:0]  offs [12];
    offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h20,
             8'h24, 8'h0C, 8'h18, 8'h28, 8'hFC, 8'h11};

    switches       = '0;
    buttons        = '0;
    rst            = 1'b1;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_web        = 1'b0;
    rst_step(32'h0, 32'h0);
    rst_step(32'h0, 32'h0);

    // Full-word write then read back
    step(32'h0000_0040, 32'hDEADBEEF, 1'b1);
    step(32'h0000_0040, 32'h0, 1'b0);
    check("wr_rd_0x40", mem_data, 32'hDEADBEEF);

    // Read-first on same-cycle read/write
    step(32'h0000_0044, 32'h5, 1'b1);
    step(32'h0000_0044, 32'h1, 1'b1);
    check("read_first_old", mem_data, 32'h5);
    step(32'h0000_0044, 32'h0, 1'b0);
    check("read_first_new", mem_data, 32'h1);

    // Switch synchronizer latency
    switches = 16'h00A5;
    idle();
    step(32'h000F_0000, 32'h0, 1'b0);
    check("sw_early", mem_data, 32'h0);
    step(32'h000F_0000, 32'h0, 1'b0);
    check("sw_sync", mem_data, 32'h0000_00A5);

    // Button edge latch, W1C, and set-beats-clear
    buttons = 5'h04;
    idle();
    buttons = 5'h00;
    idle();
    idle();
    step(32'h000F_0008, 32'h0, 1'b0);
    check("btn_edge_set", mem_data, 32'h4);
    step(32'h000F_0008, 32'h0, 1'b0);
    check("btn_edge_sticky", mem_data, 32'h4);
    step(32'h000F_0008, 32'h4, 1'b1);
    step(32'h000F_0008, 32'h0, 1'b0);
    check("btn_edge_clr", mem_data, 32'h0);
    buttons = 5'h04;
    idle();
    idle();
    step(32'h000F_0008, 32'h4, 1'b1);
    step(32'h000F_0008, 32'h0, 1'b0);
    check("btn_edge_set_wins", mem_data, 32'h4);
    buttons = 5'h00;

    // LED write, reset clears LED but not RAM; write during reset dropped
    step(32'h000F_0010, 32'h0000_1234, 1'b1);
    check("led_write", {16'h0, led}, 32'h1234);
    rst_step(32'h0000_0040, 32'h0BAD_F00D);
    check("led_reset", {16'h0, led}, 32'h0);
    check("mem_data_reset", mem_data, 32'h0);
    step(32'h0000_0040, 32'h0, 1'b0);
    check("ram_keeps", mem_data, 32'hDEADBEEF);

    // Timers
    rst_step(32'h0, 32'h0);
    repeat (12) idle();
    step(32'h000F_0024, 32'h0, 1'b0);
`ifdef MMIO_TIMER_EN
    check("ms_after_12", mem_data, 32'd3);
`else
    check("ms_disabled", mem_data, 32'd0);
`endif
    step(32'h000F_0024, 32'd100, 1'b1);
    step(32'h000F_0024, 32'h0, 1'b0);
`ifdef MMIO_TIMER_EN
    check("ms_load", mem_data, 32'd100);
`else
    check("ms_load_ignored", mem_data, 32'd0);
`endif
    repeat (3) idle();
    step(32'h000F_0024, 32'h0, 1'b0);
`ifdef MMIO_TIMER_EN
    check("ms_tick", mem_data, 32'd101);
`else
    check("ms_still_zero", mem_data, 32'd0);
`endif
    step(32'h000F_0020, 32'h0, 1'b0);
`ifndef MMIO_TIMER_EN
    check("cycle_disabled", mem_data, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) switches = 16'($urandom);
      if ($urandom_range(0, 5) == 0) buttons  = 5'($urandom);
      a = $urandom;
      if (r < 2) begin
        a[19:16] = 4'($urandom_range(0, 14));
        rst_step(a, $urandom);
      end else if (r < 45) begin
        a[19:16] = 4'hF;
        a[7:0]   = offs[$urandom_range(0, 11)];
        step(a, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        a[19:16] = 4'($urandom_range(0, 14));
        a[15:8]  = 8'($urandom_range(0, 1));
        step(a, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_WID, default 14, word-address width of the backing RAM (2^MEM_WID 32-bit words).
REQ-002 SHALL have parameter MS_DIV, default 100000, clk cycles per millisecond tick.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_addr  input  32  byte address from the data cache.
REQ-006 mem_write_data  input  32  full-word write data.
REQ-007 mem_web  input  1  write enable, 1 = write this cycle.
REQ-008 mem_data  output  32  registered read data.
REQ-009 switches  input  16  raw board switches, asynchronous.
REQ-010 buttons  input  5  raw board buttons, asynchronous, active-high.
REQ-011 led  output  16  LED register.
REQ-012 seg_data  output  32  seven-segment display register.

Function
REQ-013 Region SHALL be MMIO when mem_addr[19:16] == 4'hF, otherwise RAM.
REQ-014 RAM word index SHALL be mem_addr[MEM_WID+1:2]; mem_addr[1:0] and upper bits are ignored; accesses are full-word only.
REQ-015 Read latency SHALL be exactly 1 cycle: mem_data at cycle N+1 reflects mem_addr at posedge N.
REQ-016 RAM write SHALL occur at posedge when mem_web=1 and the region is RAM.
REQ-017 Same-cycle read and write to one RAM word SHALL return the old data (read-first).
REQ-018 switches and buttons SHALL each pass through a 2-flop synchronizer before any use.
REQ-019 MMIO map, offset mem_addr[7:0]:
  0x00 SW RO (synchronized switches, zero-extended)
  0x04 BTN RO (synchronized level)
  0x08 BTN_EDGE W1C, sticky rising-edge latch per button
  0x10 LED RW [15:0]
  0x14 SEG RW [31:0]
  0x20 CYCLE RO
  0x24 MS RW
REQ-020 A BTN_EDGE bit SHALL set on a synchronized 0->1 transition; if set and clear land on the same bit in the same cycle, set wins.
REQ-021 MMIO writes to RO or unmapped offsets SHALL be ignored; unmapped reads SHALL return 0.
REQ-022 LED and SEG SHALL update at the posedge of the write; led and seg_data SHALL be driven directly from the registers.
REQ-023 Reads SHALL have no side effects; repeated reads of one address across multiple cycles are safe.

Reset
REQ-024 On rst: mem_data, led, seg_data, BTN_EDGE, synchronizers, and timer registers SHALL be 0.
REQ-025 RAM contents SHALL NOT be cleared by rst; they are zero at configuration.
REQ-026 An access (read or write) that coincides with rst SHALL be dropped.

Configuration
REQ-027 Macro MMIO_TIMER_EN:
  defined -> CYCLE is a free-running 32-bit counter that wraps at 2^32; MS increments once per MS_DIV cycles via a prescaler; a write to MS loads mem_write_data and clears the prescaler; a write has priority over a same-cycle increment.
  undefined -> CYCLE and MS read 0, writes to them are ignored, and no timer logic is synthesized.

Structure
REQ-028 MMIO base nibble (4'hF) and all register offsets SHALL live in the shared constants package used by the data cache.
REQ-029 The MMIO register file SHALL be one sub-module, mmio_regs, holding the synchronizers, edge latch, LED/SEG, and timer; the top level holds the RAM and the read mux.

Verification
REQ-030 Write 0xDEADBEEF to 0x0000_0040, then read 0x40 -> mem_data = 0xDEADBEEF one cycle after the read address.
REQ-031 Write 0x1 and read 0x44 in the same cycle (prior value 0x5) -> next-cycle mem_data = 0x5; a following read returns 0x1.
REQ-032 switches = 0x00A5 -> read 0x000F_0000 returns 0x000000A5 no earlier than 3 cycles after the switch change.
REQ-033 Pulse buttons[2] -> BTN_EDGE reads 0x4 and stays set; write 0x4 to 0x000F_0008 -> reads 0x0; a rising edge in the same cycle as the W1C -> reads 0x4.
REQ-034 Write 0x1234 to 0x000F_0010 -> led = 0x1234 the next cycle; assert rst -> led = 0 and RAM word 0x40 still 0xDEADBEEF.
REQ-035 With MMIO_TIMER_EN and MS_DIV=4: after 12 cycles MS reads 3; write 100 to MS -> reads 100, then 101 after 4 cycles. Without MMIO_TIMER_EN, reads of 0x20/0x24 return 0.
